// File: rtl/comp_seq.sv
// Sequential unsigned magnitude comparator: walks the operands one nibble per
// clock from the most significant end and stops at the first difference.

module comp_seq_nib (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       lt,
  output logic       eq
);

  // Bit-serial ripple from the MSB: the first differing bit decides.
  logic [4:0] g_chain;
  logic [4:0] l_chain;

  always_comb begin
    g_chain = '0;
    l_chain = '0;
    for (int i = 3; i >= 0; i--) begin
      g_chain[i] = g_chain[i+1] | (~l_chain[i+1] & a[i] & ~b[i]);
      l_chain[i] = l_chain[i+1] | (~g_chain[i+1] & ~a[i] & b[i]);
    end
  end

  assign gt = g_chain[0];
  assign lt = l_chain[0];
  assign eq = ~(g_chain[0] | l_chain[0]);

endmodule

module comp_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] a_q, a_nx;
  logic [WIDTH-1:0] b_q, b_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic             busy_nx, done_nx;
  logic             gt_nx, lt_nx, eq_nx;

  logic nib_gt, nib_lt, nib_eq;

  // Captured operands shift left on each equal nibble, so the nibble under
  // test is always the top one; idx only tracks how many remain.
  comp_seq_nib u_nib (
    .a  (a_q[WIDTH-1 -: 4]),
    .b  (b_q[WIDTH-1 -: 4]),
    .gt (nib_gt),
    .lt (nib_lt),
    .eq (nib_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      A_gt_B <= 1'b0;
      A_lt_B <= 1'b0;
      A_eq_B <= 1'b0;
    end else begin
      state  <= state_nx;
      a_q    <= a_nx;
      b_q    <= b_nx;
      idx    <= idx_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      A_gt_B <= gt_nx;
      A_lt_B <= lt_nx;
      A_eq_B <= eq_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    idx_nx   = idx;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    gt_nx    = A_gt_B;
    lt_nx    = A_lt_B;
    eq_nx    = A_eq_B;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          a_nx     = A;
          b_nx     = B;
          idx_nx   = IDX_TOP;
          gt_nx    = 1'b0;
          lt_nx    = 1'b0;
          eq_nx    = 1'b0;
          busy_nx  = 1'b1;
          state_nx = CMP;
        end else begin
          state_nx = IDLE;
        end
      end

      CMP: begin
        if (nib_gt) begin
          gt_nx    = 1'b1;
          done_nx  = 1'b1;
          state_nx = DONE;
        end else if (nib_lt) begin
          lt_nx    = 1'b1;
          done_nx  = 1'b1;
          state_nx = DONE;
        end else if (nib_eq && (idx == '0)) begin
          eq_nx    = 1'b1;
          done_nx  = 1'b1;
          state_nx = DONE;
        end else begin
          a_nx     = a_q << 4;
          b_nx     = b_q << 4;
          idx_nx   = idx - 1'b1;
          busy_nx  = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_comp_seq.sv
// Bench for comp_seq (WIDTH=16): directed scenarios with literal expectations
// plus randomized traffic checked cycle by cycle against a latency/result model.

module tb_comp_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, A_gt_B, A_lt_B, A_eq_B;

  int tests = 0;
  int fails = 0;

  comp_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .A_gt_B (A_gt_B),
    .A_lt_B (A_lt_B),
    .A_eq_B (A_eq_B)
  );

  always #5 clk = ~clk;

  // Reference: how many nibbles are inspected and which flag results.
  // flags are packed {gt, lt, eq}.
  task automatic ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int k, output logic [2:0] f);
    int n;
    int an, bn;
    k = W / 4;
    f = 3'b001;
    for (n = 0; n < W / 4; n++) begin
      an = int'((a >> (W - 4 - 4 * n)) & 16'hF);
      bn = int'((b >> (W - 4 - 4 * n)) & 16'hF);
      if (an != bn) begin
        k = n + 1;
        f = (an > bn) ? 3'b100 : 3'b010;
        break;
      end
    end
  endtask

  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [2:0] m_flags = 3'b000;
  logic [2:0] m_res = 3'b000;
  int         m_left = 0;

  always @(posedge clk) begin
    int k;
    logic [2:0] r;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_flags = 3'b000; m_left = 0;
    end else if (!m_busy && start) begin
      ref_cmp(A, B, k, r);
      m_res = r; m_left = k; m_busy = 1'b1; m_done = 1'b0; m_flags = 3'b000;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_flags = m_res;
      end
    end else begin
      m_done = 1'b0;
    end
    #1;
    tests++;
    if ({busy, done, A_gt_B, A_lt_B, A_eq_B} !== {m_busy, m_done, m_flags}) begin
      fails++;
      $display("FAIL cycle_model t=%0t busy,done,gt,lt,eq got %b expected %b",
               $time, {busy, done, A_gt_B, A_lt_B, A_eq_B}, {m_busy, m_done, m_flags});
    end
  end

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s busy,done,gt,lt,eq got %b expected %b", name, got, exp);
    end
  endtask

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called half a cycle after the accepting edge; counts edges until done.
  task automatic expect_done(input string name, input int k, input logic [2:0] f);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if (done === 1'b1) begin cyc = i; break; end
    end
    tests++;
    if (cyc != k) begin
      fails++;
      $display("FAIL %s_latency got %0d expected %0d", name, cyc, k);
    end
    check(name, {busy, done, A_gt_B, A_lt_B, A_eq_B}, {2'b01, f});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b00000);
    rst = 1'b0;

    go(16'h1234, 16'h1234);
    check("eq_busy", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b10000);
    expect_done("eq_1234", 4, 3'b001);

    go(16'hF000, 16'h0FFF);
    expect_done("gt_early", 1, 3'b100);
    repeat (3) @(negedge clk);
    check("gt_held", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b00100);

    go(16'h1230, 16'h1231);
    expect_done("lt_late", 4, 3'b010);
    go(16'h1200, 16'h1300);
    expect_done("lt_third", 2, 3'b010);

    // start re-asserted while busy must be ignored
    @(negedge clk);
    start = 1'b1; A = 16'h0000; B = 16'hFFFF;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000;
    @(posedge clk); #2;
    check("busy_ignore", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b01010);
    @(negedge clk);
    start = 1'b0;

    // back-to-back start in the DONE cycle
    go(16'h00F0, 16'h0F00);
    expect_done("b2b_first", 2, 3'b010);
    @(negedge clk);
    start = 1'b1; A = 16'hAAAA; B = 16'hAAAA;
    @(negedge clk);
    start = 1'b0;
    check("b2b_cleared", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b10000);
    expect_done("b2b_eq", 4, 3'b001);

    // reset mid-operation
    go(16'h5555, 16'h5555);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b00000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_no_done", {busy, done, A_gt_B, A_lt_B, A_eq_B}, 5'b00000);
    go(16'h0001, 16'h0000);
    expect_done("rst_then_gt", 4, 3'b100);

    // randomized traffic; nibble-correlated operands exercise long compares
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) == 0);
      A     = W'($urandom);
      case ($urandom_range(0, 2))
        0: B = A;
        1: B = A ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
        default: B = W'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
